// File: rtl/trace_pkg.sv
// Shared constants and types for the ASCII trace-line parser.
// Contains no logic, so it adds no latency and has no backpressure behaviour.
package trace_pkg;

  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_TAB = 8'h09;
  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_LA  = 8'h61;
  localparam logic [7:0] CH_UA  = 8'h41;
  localparam logic [7:0] CH_LX  = 8'h78;
  localparam logic [7:0] CH_UR  = 8'h52;
  localparam logic [7:0] CH_UW  = 8'h57;

  // Setting bit 5 maps an ASCII upper-case letter onto its lower-case form.
  localparam logic [7:0] CASE_BIT = 8'h20;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_ADDR  = 2'd1,
    S_SKIP  = 2'd2
  } state_t;

  typedef struct packed {
    logic       is_hex;
    logic [3:0] val;
  } hex_t;

  // A record is {is_write, address}.
  function automatic int rec_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with registered wrap-bit pointers; a write shows at the head one edge after the push.
// A push while full is refused unless a pop happens in the same cycle; a pop while empty is ignored.
module sync_fifo #(
  parameter int DW = 33,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  output logic          push_acc,
  input  logic          pop,
  output logic          valid,
  output logic [DW-1:0] head
);

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [DW-1:0] mem [2**AW];
  logic          empty;
  logic          full;
  logic          do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // On full, a coincident pop frees the slot being written, so the push is safe.
  assign do_pop   = pop && !empty;
  assign push_acc = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // The storage array is not reset, so the head is forced to zero while empty.
  assign valid = !empty;
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/trace_addr_parser.sv
// Parses ASCII trace lines into {is_write, address} records; a record appears at the output one edge after its LF.
// The input byte stream is never stalled; records wait in the FIFO for rec_ready, and lines are dropped when the FIFO is full.
module trace_addr_parser
  import trace_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int FIFO_AW = 3,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              rec_valid,
  output logic              rec_wr,
  output logic [ADDR_W-1:0] rec_addr,
  input  logic              rec_ready,
  output logic [CNT_W-1:0]  line_count,
  output logic              err_badchar,
  output logic              err_overflow
);

  localparam int REC_W = rec_width(ADDR_W);

  function automatic hex_t hex_decode(input logic [7:0] b);
    hex_t r;
    r.is_hex = 1'b1;
    r.val    = 4'd0;
    if (b >= CH_0 && b <= CH_0 + 8'd9)
      r.val = 4'(b - CH_0);
    else if (b >= CH_LA && b <= CH_LA + 8'd5)
      r.val = 4'(b - CH_LA + 8'd10);
    else if (b >= CH_UA && b <= CH_UA + 8'd5)
      r.val = 4'(b - CH_UA + 8'd10);
    else
      r.is_hex = 1'b0;
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] acc_q, acc_d;
  logic [1:0]        ndig_q, ndig_d;
  logic              wr_q, wr_d;
  logic              push;
  logic              push_acc;
  logic              bad;

  hex_t hx;
  logic is_ws, is_lf, is_op, is_w, is_x;

  assign hx    = hex_decode(in_byte);
  assign is_ws = (in_byte == CH_SP) || (in_byte == CH_TAB) || (in_byte == CH_CR);
  assign is_lf = (in_byte == CH_LF);
  assign is_w  = ((in_byte | CASE_BIT) == (CH_UW | CASE_BIT));
  assign is_op = is_w || ((in_byte | CASE_BIT) == (CH_UR | CASE_BIT));
  assign is_x  = ((in_byte | CASE_BIT) == CH_LX);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ndig_d  = ndig_q;
    wr_d    = wr_q;
    push    = 1'b0;
    bad     = 1'b0;
    if (in_valid) begin
      case (state_q)
        S_START: begin
          if (is_op) begin
            wr_d    = is_w;
            acc_d   = '0;
            ndig_d  = 2'd0;
            state_d = S_ADDR;
          end else if (hx.is_hex) begin
            wr_d    = 1'b0;
            acc_d   = ADDR_W'(hx.val);
            ndig_d  = 2'd1;
            state_d = S_ADDR;
          end else if (!(is_ws || is_lf)) begin
            bad     = 1'b1;
            state_d = S_SKIP;
          end
        end
        S_ADDR: begin
          if (hx.is_hex) begin
            // Shifting left keeps the low ADDR_W bits of an over-long address.
            acc_d  = {acc_q[ADDR_W-5:0], hx.val};
            ndig_d = (ndig_q == 2'd0) ? 2'd1 : 2'd2;
          end else if (is_x && ndig_q == 2'd1 && acc_q == '0) begin
            acc_d  = '0;
            ndig_d = 2'd0;
          end else if (is_lf) begin
            if (ndig_q != 2'd0) push = 1'b1;
            else                bad  = 1'b1;
            state_d = S_START;
          end else if (!is_ws) begin
            bad     = 1'b1;
            state_d = S_SKIP;
          end
        end
        S_SKIP: begin
          if (is_lf) state_d = S_START;
        end
        default: state_d = S_START;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_START;
      acc_q        <= '0;
      ndig_q       <= 2'd0;
      wr_q         <= 1'b0;
      line_count   <= '0;
      err_badchar  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ndig_q  <= ndig_d;
      wr_q    <= wr_d;
      if (push_acc)          line_count   <= line_count + CNT_W'(1);
      if (bad)               err_badchar  <= 1'b1;
      if (push && !push_acc) err_overflow <= 1'b1;
    end
  end

  logic [REC_W-1:0] head;

  sync_fifo #(
    .DW(REC_W),
    .AW(FIFO_AW)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (push),
    .push_data({wr_q, acc_q}),
    .push_acc (push_acc),
    .pop      (rec_ready),
    .valid    (rec_valid),
    .head     (head)
  );

  assign rec_wr   = head[ADDR_W];
  assign rec_addr = head[ADDR_W-1:0];

endmodule

// File: tb/tb_trace_addr_parser.sv
// Scoreboard bench for trace_addr_parser: expected records are queued as lines are sent and compared as the DUT pops them.
module tb_trace_addr_parser;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        rec_valid;
  logic        rec_wr;
  logic [31:0] rec_addr;
  logic        rec_ready;
  logic [15:0] line_count;
  logic        err_badchar;
  logic        err_overflow;

  int n_checks = 0;
  int n_errors = 0;
  logic [32:0] exp_q[$];

  trace_addr_parser #(.ADDR_W(32), .FIFO_AW(3), .CNT_W(16)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_byte     (in_byte),
    .rec_valid   (rec_valid),
    .rec_wr      (rec_wr),
    .rec_addr    (rec_addr),
    .rec_ready   (rec_ready),
    .line_count  (line_count),
    .err_badchar (err_badchar),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 64'(rec_valid), 64'd0);
    check({tag, "_wr"},    64'(rec_wr), 64'd0);
    check({tag, "_addr"},  64'(rec_addr), 64'd0);
    check({tag, "_cnt"},   64'(line_count), 64'd0);
    check({tag, "_bad"},   64'(err_badchar), 64'd0);
    check({tag, "_ovf"},   64'(err_overflow), 64'd0);
  endtask

  // Each byte is driven 1 time unit after a rising edge and consumed at the next one.
  task automatic send_line(input string s, input bit ok, input bit wr,
                           input logic [31:0] a, input bit pop_lf = 1'b0);
    if (ok) exp_q.push_back({wr, a});
    for (int i = 0; i < s.len(); i++) begin
      in_valid = 1'b1;
      in_byte  = s[i];
      if (pop_lf && i == s.len() - 1) rec_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (pop_lf) rec_ready = 1'b0;
  endtask

  task automatic drain();
    rec_ready = 1'b1;
    for (int k = 0; k < 100 && (exp_q.size() != 0 || rec_valid); k++) begin
      @(posedge clk);
      #1;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
    check("drain_valid", 64'(rec_valid), 64'd0);
    rec_ready = 1'b0;
  endtask

  task automatic do_reset();
    rstn     = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // Monitor: a handshake seen here completes at the following rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn && rec_valid && rec_ready) begin
        if (exp_q.size() == 0)
          check("spurious_rec", 64'({rec_wr, rec_addr}), 64'h1_0000_0000_0);
        else
          check("rec", 64'({rec_wr, rec_addr}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t limit %0d", $time, 200000);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    rec_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rstn = 1'b1;

    send_line("R 1A2b\n", 1'b1, 1'b0, 32'h0000_1A2B);
    check("t1_valid", 64'(rec_valid), 64'd1);
    check("t1_head", 64'({rec_wr, rec_addr}), 64'({1'b0, 32'h0000_1A2B}));
    check("t1_cnt", 64'(line_count), 64'd1);
    drain();

    do_reset();
    send_line("W 0x00400010\r\n", 1'b1, 1'b1, 32'h0040_0010);
    check("t2_bad", 64'(err_badchar), 64'd0);
    check("t2_ovf", 64'(err_overflow), 64'd0);
    drain();

    do_reset();
    send_line("R 123456789\n", 1'b1, 1'b0, 32'h2345_6789);
    send_line("\n\n  \n", 1'b0, 1'b0, 32'h0);
    check("t3_cnt", 64'(line_count), 64'd1);
    check("t3_bad", 64'(err_badchar), 64'd0);
    drain();

    do_reset();
    send_line("R 12G4\n", 1'b0, 1'b0, 32'h0);
    check("t4_bad", 64'(err_badchar), 64'd1);
    check("t4_novalid", 64'(rec_valid), 64'd0);
    send_line("W 5\n", 1'b1, 1'b1, 32'h5);
    check("t4_cnt", 64'(line_count), 64'd1);
    drain();

    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i == 8) check("t5_ovf_before", 64'(err_overflow), 64'd0);
      send_line($sformatf("R %0h\n", i + 1), i < 8, 1'b0, 32'(i + 1));
    end
    check("t5_ovf", 64'(err_overflow), 64'd1);
    check("t5_cnt8", 64'(line_count), 64'd8);
    send_line("W ABC\n", 1'b1, 1'b1, 32'h0000_0ABC, 1'b1);
    check("t5_cnt9", 64'(line_count), 64'd9);
    drain();

    do_reset();
    send_line("R 12", 1'b0, 1'b0, 32'h0);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check_zero("t6_rst");
    rstn = 1'b1;
    send_line("R 3\n", 1'b1, 1'b0, 32'h3);
    check("t6_cnt", 64'(line_count), 64'd1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trace_addr_parser.md
# trace_addr_parser

Consumes the raw byte stream produced by the SD-card file reader (`outbyte`/`outen`, one byte per strobe, no backpressure) while it reads the access trace `art.trace`. Converts each ASCII trace line into a binary memory-access record `{is_write, address}`. Buffers records in a small FIFO and presents them on a valid/ready interface to the downstream LRU cache model. Trace format per line: optional op letter (R/W), optional whitespace, optional `0x`, hex digits, LF terminator.

## Interface
- `ADDR_W`, 32: address width; hex digits beyond this are truncated from the top.
- `FIFO_AW`, 3: FIFO address bits; depth = 2**FIFO_AW (8).
- `CNT_W`, 16: width of the line counter.

Ports:
- `clk`  in  1  single clock, shared with the SD reader.
- `rstn`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  byte strobe from the file reader; no ready, so a byte is never stalled.
- `in_byte`  in  8  ASCII byte, sampled when `in_valid`=1.
- `rec_valid`  out  1  FIFO non-empty.
- `rec_wr`  out  1  1 = write access, 0 = read; valid with `rec_valid`.
- `rec_addr`  out  ADDR_W  access address; valid with `rec_valid`.
- `rec_ready`  in  1  consumer pops the head when `rec_valid & rec_ready`.
- `line_count`  out  CNT_W  records successfully pushed; wraps modulo 2**CNT_W.
- `err_badchar`  out  1  sticky; set when any line is rejected.
- `err_overflow`  out  1  sticky; set when a valid record is dropped because the FIFO is full.

## Operation
Character classes:
- WS: space, tab, CR.
- HEX: 0-9, a-f, A-F.
- OP: R, r, W, w.
- LF.
- Anything else is OTHER.

Parser FSM, which advances only on `in_valid`:
- **S_START**
  - WS or LF: stay. Empty lines are ignored.
  - OP: `wr_q` = (W or w); clear `acc` and `ndig`; go to S_ADDR.
  - HEX: `wr_q` = 0; `acc` = digit; `ndig` = 1; go to S_ADDR.
  - OTHER: set `err_badchar`; go to S_SKIP.
- **S_ADDR**
  - HEX: `acc` = {acc[ADDR_W-5:0], digit}; `ndig` saturates at 2 (only zero / one / more is tracked).
  - `x`/`X` with `ndig`=1 and `acc`=0 (`0x` prefix): clear `acc`; `ndig` = 0.
  - WS: ignored.
  - LF with `ndig`>0: push `{wr_q, acc}`; go to S_START.
  - LF with `ndig`=0: set `err_badchar`; go to S_START.
  - OTHER, including a second OP or a misplaced `x`: set `err_badchar`; go to S_SKIP.
- **S_SKIP**
  - LF: go to S_START.
  - Anything else: stay.

Push rules:
- A push to a non-full FIFO increments `line_count`.
- A push to a full FIFO is dropped and sets `err_overflow`. Exception: if a pop happens in the same cycle, the push is accepted.
- A pop on an empty FIFO is ignored.
- Records leave the FIFO in arrival order.

Reset (`rstn`=0 at a rising edge):
- FSM goes to S_START; `acc`, `ndig` and `wr_q` clear.
- FIFO becomes empty; any partial line is discarded.
- Every output is 0: `rec_valid`, `rec_wr`, `rec_addr`, `line_count`, `err_badchar`, `err_overflow`.
- Sticky flags clear only on reset.

## Timing
- Byte to state update: 1 cycle.
- LF accepted at edge N: the record is written at edge N. `rec_valid`/`rec_addr` are high/valid after edge N (first-word-fall-through, registered pointers). `line_count` updates at edge N.
- Pop at edge N: the next head, or `rec_valid`=0, is visible after edge N.
- Back-to-back `in_valid` every cycle is supported at full rate. No combinational path from `in_byte` to any output.
- `rec_valid` must not depend on `rec_ready`. `rec_addr`/`rec_wr` are stable while `rec_valid & !rec_ready`.

## Structure
- Package `trace_pkg` holds:
  - ASCII constants (LF, CR, SP, TAB, '0', 'a', 'A', 'x', 'R', 'W').
  - FSM state encoding (S_START, S_ADDR, S_SKIP, 2 bits).
  - The record width, ADDR_W+1.
- Sub-module `sync_fifo` (params `DW`, `AW`): registered pointers with an extra wrap bit for full/empty, FWFT head output, simultaneous push/pop on full allowed. The parser instantiates it with DW = ADDR_W+1.
- The hex-digit decode is a local function: byte in, 4-bit value plus is_hex flag out.

## Test plan
1. Bytes `R 1A2b\n` -> one record {wr=0, addr=0x00001A2B}; `rec_valid` high the cycle after LF; `line_count`=1.
2. `W 0x00400010\r\n` -> {wr=1, addr=0x00400010}; CR ignored; no error flags.
3. `R 123456789\n` (9 digits) -> addr=0x23456789, no error. `\n\n  \n` -> no record, no error.
4. `R 12G4\n` then `W 5\n` -> first line dropped, `err_badchar`=1; one record {1, 0x5}; `line_count`=1.
5. `rec_ready`=0, feed 9 valid lines -> 8 stored and `err_overflow`=1; raise `rec_ready` -> 8 records drained in order; the 9th is absent. With the FIFO full and a pop coincident with the LF, the push is accepted.
6. Feed `R 12`, pulse `rstn` low for 1 cycle, then `R 3\n` -> only {0, 0x3}. All outputs read 0 during reset.
